// File: rtl/reg_file_sweep_pkg.sv
// Shared definitions for the sweeping register file: bulk-clear FSM states and
// default geometry constants, also used by the decode stage.
package reg_file_sweep_pkg;

   typedef enum logic [1:0] {
      CLR_IDLE  = 2'd0,
      CLR_SWEEP = 2'd1,
      CLR_DONE  = 2'd2
   } clr_state_e;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_ADDR_W = 5;

endpackage

// File: rtl/reg_file_clear_fsm.sv
// Bulk-clear sequencer: walks every register address once, one per cycle,
// then emits a single done pulse. Owns busy/clrDone timing.
module reg_file_clear_fsm
   import reg_file_sweep_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   output logic              busy,
   output logic              clr_done,
   output logic [ADDR_W-1:0] sweep_addr
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CLR_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // clear is only honoured from IDLE; requests during SWEEP/DONE are dropped
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         CLR_IDLE: begin
            if (clear) begin
               state_d = CLR_SWEEP;
               cnt_d   = '0;
            end
         end
         CLR_SWEEP: begin
            if (cnt_q == LAST_ADDR) begin
               state_d = CLR_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         CLR_DONE: state_d = CLR_IDLE;
         default:  state_d = CLR_IDLE;
      endcase
   end

   assign busy       = (state_q == CLR_SWEEP);
   assign clr_done   = (state_q == CLR_DONE);
   assign sweep_addr = cnt_q;

endmodule

// File: rtl/reg_file_sweep.sv
// Two-read/one-write register file with optional zero register, same-cycle
// write-to-read bypass and a sequential bulk-clear engine.
module reg_file_sweep
   import reg_file_sweep_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              regWrite,
   input  logic              select,
   input  logic [ADDR_W-1:0] rd0,
   input  logic [ADDR_W-1:0] rd1,
   input  logic [DATA_W-1:0] writeData,
   input  logic [ADDR_W-1:0] rs,
   input  logic [ADDR_W-1:0] rt,
   input  logic              clear,
   output logic [DATA_W-1:0] regRs,
   output logic [DATA_W-1:0] regRt,
   output logic              busy,
   output logic              clrDone
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [ADDR_W-1:0] wa;
   logic [ADDR_W-1:0] sweep_addr;
   logic              we;

   reg_file_clear_fsm #(
      .ADDR_W (ADDR_W)
   ) u_clear_fsm (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .busy       (busy),
      .clr_done   (clrDone),
      .sweep_addr (sweep_addr)
   );

   assign wa = select ? rd1 : rd0;
   // Effective write: blocked while sweeping and never to the hardwired zero register
   assign we = regWrite && !busy && !(ZERO_REG && (wa == '0));

   always_comb begin
      mem_d = mem_q;
      if (busy) begin
         mem_d[sweep_addr] = '0;
      end else if (we) begin
         mem_d[wa] = writeData;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   always_comb begin
      regRs = mem_q[rs];
      if (ZERO_REG && (rs == '0)) begin
         regRs = '0;
      end else if (BYPASS && we && (rs == wa)) begin
         regRs = writeData;
      end
   end

   always_comb begin
      regRt = mem_q[rt];
      if (ZERO_REG && (rt == '0)) begin
         regRt = '0;
      end else if (BYPASS && we && (rt == wa)) begin
         regRt = writeData;
      end
   end

endmodule

// File: tb/tb_reg_file_sweep.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural model of the register file and its bulk clear.
module tb_reg_file_sweep;

   logic        clk = 1'b0;
   logic        rst;
   logic        reg_write, sel, clear;
   logic [4:0]  rd0, rd1, rs, rt;
   logic [31:0] wd;
   logic [31:0] reg_rs, reg_rt;
   logic        busy, clr_done;

   logic        s_we, s_sel, s_clear;
   logic [2:0]  s_rd0, s_rd1, s_rs, s_rt;
   logic [7:0]  s_wd;
   logic [7:0]  s_reg_rs, s_reg_rt;
   logic        s_busy, s_done;

   int total = 0;
   int bad   = 0;

   logic [31:0] m [32];
   int          sweep_left;
   bit          done_now;

   always #5 clk = ~clk;

   reg_file_sweep dut (
      .clk       (clk),
      .reset     (rst),
      .regWrite  (reg_write),
      .select    (sel),
      .rd0       (rd0),
      .rd1       (rd1),
      .writeData (wd),
      .rs        (rs),
      .rt        (rt),
      .clear     (clear),
      .regRs     (reg_rs),
      .regRt     (reg_rt),
      .busy      (busy),
      .clrDone   (clr_done)
   );

   reg_file_sweep #(
      .DATA_W (8),
      .ADDR_W (3)
   ) dut_s (
      .clk       (clk),
      .reset     (rst),
      .regWrite  (s_we),
      .select    (s_sel),
      .rd0       (s_rd0),
      .rd1       (s_rd1),
      .writeData (s_wd),
      .rs        (s_rs),
      .rt        (s_rt),
      .clear     (s_clear),
      .regRs     (s_reg_rs),
      .regRt     (s_reg_rt),
      .busy      (s_busy),
      .clrDone   (s_done)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] a);
      logic [4:0] wa;
      wa = sel ? rd1 : rd0;
      if (a == 5'd0) return 32'd0;
      if (sweep_left == 0 && reg_write && a == wa) return wd;
      return m[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m[i] = '0;
      sweep_left = 0;
      done_now   = 1'b0;
   endtask

   // Effect of one rising edge, using the inputs that were applied before it
   task automatic model_edge();
      logic [4:0] wa;
      bit         was_done;
      wa = sel ? rd1 : rd0;
      if (sweep_left > 0) begin
         m[32 - sweep_left] = '0;
         sweep_left--;
         done_now = (sweep_left == 0);
      end else begin
         was_done = done_now;
         done_now = 1'b0;
         if (reg_write && wa != 5'd0) m[wa] = wd;
         if (clear && !was_done) sweep_left = 32;
      end
   endtask

   task automatic tick();
      #1;
      check_eq("regRs", reg_rs, model_read(rs));
      check_eq("regRt", reg_rt, model_read(rt));
      check_eq("busy", {31'd0, busy}, {31'd0, sweep_left > 0});
      check_eq("clrDone", {31'd0, clr_done}, {31'd0, done_now});
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_idle();
      reg_write = 1'b0;
      clear     = 1'b0;
   endtask

   initial begin
      int nb, nd;
      rst = 1'b1;
      reg_write = 0; sel = 0; clear = 0; rd0 = 0; rd1 = 0; rs = 0; rt = 0; wd = 0;
      s_we = 0; s_sel = 0; s_clear = 0; s_rd0 = 0; s_rd1 = 0; s_rs = 0; s_rt = 0; s_wd = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      rs = 5'd3; rt = 5'd31;
      #1;
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_done", {31'd0, clr_done}, 32'd0);
      check_eq("rst_rs", reg_rs, 32'd0);

      // Small geometry instance: 8 registers of 8 bits
      s_we = 1; s_rd0 = 3'd5; s_wd = 8'hA5; s_rs = 3'd5;
      #1 check_eq("s_bypass", {24'd0, s_reg_rs}, 32'h0000_00A5);
      tick();
      s_we = 0;
      #1 check_eq("s_read", {24'd0, s_reg_rs}, 32'h0000_00A5);
      s_clear = 1;
      tick();
      s_clear = 0;
      nb = 0; nd = 0;
      for (int k = 0; k < 12; k++) begin
         if (s_busy) nb++;
         if (s_done) nd++;
         tick();
      end
      check_eq("s_busy_len", nb, 32'd8);
      check_eq("s_done_cnt", nd, 32'd1);
      check_eq("s_cleared", {24'd0, s_reg_rs}, 32'd0);

      // 1: two writes through rd1, then read both
      reg_write = 1; sel = 1; rd1 = 5'd1; wd = 32'd1; tick();
      rd1 = 5'd3; wd = 32'd3; tick();
      set_idle(); rs = 5'd1; rt = 5'd3;
      #1 check_eq("t1_rs", reg_rs, 32'd1);
      check_eq("t1_rt", reg_rt, 32'd3);
      tick();

      // 2: zero register and bypass
      reg_write = 1; sel = 0; rd0 = 5'd0; wd = 32'hDEAD; rs = 5'd0; tick();
      set_idle();
      #1 check_eq("t2_zero", reg_rs, 32'd0);
      reg_write = 1; sel = 0; rd0 = 5'd4; wd = 32'h44; rs = 5'd4;
      #1 check_eq("t2_bypass", reg_rs, 32'h44);
      tick();
      set_idle(); rt = 5'd4;
      #1 check_eq("t2_rt", reg_rt, 32'h44);
      tick();

      // 3: full sweep with mid-sweep reads
      for (int i = 1; i < 32; i++) begin
         reg_write = 1; sel = 0; rd0 = 5'(i); wd = i; tick();
      end
      set_idle(); clear = 1; tick(); clear = 0;
      nb = 0;
      for (int k = 0; k < 32; k++) begin
         if (k == 10) begin
            rs = 5'd5; rt = 5'd20;
            #1 check_eq("t3_mid_rs", reg_rs, 32'd0);
            check_eq("t3_mid_rt", reg_rt, 32'd20);
         end
         if (busy) nb++;
         tick();
      end
      check_eq("t3_busy_len", nb, 32'd32);
      check_eq("t3_done", {31'd0, clr_done}, 32'd1);
      tick();
      for (int a = 0; a < 32; a++) begin
         rs = 5'(a); rt = 5'(31 - a); tick();
      end

      // 4: writes and a second clear while busy are ignored
      clear = 1; tick(); clear = 0;
      nb = 0; nd = 0;
      for (int k = 0; k < 32; k++) begin
         reg_write = 1; sel = 1; rd1 = 5'd7; wd = 32'h77; rs = 5'd7;
         clear = (k == 5);
         if (busy) nb++;
         tick();
      end
      set_idle();
      for (int k = 0; k < 4; k++) begin
         if (busy) nb++;
         if (clr_done) nd++;
         tick();
      end
      check_eq("t4_busy_len", nb, 32'd32);
      check_eq("t4_done_cnt", nd, 32'd1);
      rs = 5'd7;
      #1 check_eq("t4_reg7", reg_rs, 32'd0);

      // 5: clear and write on the same idle edge
      reg_write = 1; sel = 0; rd0 = 5'd9; wd = 32'd9; clear = 1; tick();
      set_idle(); rs = 5'd9;
      #1 check_eq("t5_held", reg_rs, 32'd9);
      repeat (34) tick();
      check_eq("t5_cleared", reg_rs, 32'd0);

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         reg_write = 1'($urandom);
         sel = 1'($urandom);
         rd0 = 5'($urandom); rd1 = 5'($urandom);
         rs = 5'($urandom); rt = 5'($urandom);
         wd = $urandom;
         clear = ($urandom_range(0, 39) == 0);
         tick();
      end
      set_idle();
      repeat (40) tick();

      // 6: asynchronous reset mid-sweep
      reg_write = 1; sel = 0; rd0 = 5'd20; wd = 32'h1234; tick();
      set_idle(); clear = 1; tick(); clear = 0;
      repeat (12) tick();
      rs = 5'd20; rt = 5'd30;
      #2 rst = 1'b1;
      #1;
      check_eq("t6_busy", {31'd0, busy}, 32'd0);
      check_eq("t6_done", {31'd0, clr_done}, 32'd0);
      check_eq("t6_rs", reg_rs, 32'd0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      nd = 0;
      for (int k = 0; k < 40; k++) begin
         if (clr_done) nd++;
         tick();
      end
      check_eq("t6_no_done", nd, 32'd0);
      reg_write = 1; sel = 1; rd1 = 5'd6; wd = 32'h66; tick();
      set_idle(); rs = 5'd6;
      #1 check_eq("t6_after", reg_rs, 32'h66);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
